// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a word-organised memory.
// Supports byte/half/word accesses, programmable wait states and the two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state, state_n;
  logic [3:0]    wait_cnt, wait_cnt_n;
  logic [AW-1:0] idx_q;
  logic          write_q;
  logic [3:0]    lanes_q, lanes_a;
  logic [31:0]   mem [MEM_DEPTH];

  logic accept, slot_open, addr_ok, size_ok, align_ok, req_err;
  logic unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign accept    = HSEL & HREADY & HTRANS[1];
  // Only states that drive HREADYOUT high close a data phase and may take a new address.
  assign slot_open = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign addr_ok   = {2'b00, HADDR[31:2]} < 32'(MEM_DEPTH);
  assign size_ok   = HSIZE <= 3'b010;
  assign align_ok  = !((HSIZE == 3'b001 && HADDR[0]) ||
                       (HSIZE == 3'b010 && HADDR[1:0] != 2'b00));
  assign req_err   = !(addr_ok && size_ok && align_ok);

  always_comb begin
    lanes_a = 4'b1111;
    case (HSIZE)
      3'b000:  lanes_a = 4'b0001 << HADDR[1:0];
      3'b001:  lanes_a = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes_a = 4'b1111;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    case (state)
      S_WAIT:  HREADYOUT = 1'b0;
      S_ERR1:  begin HREADYOUT = 1'b0; HRESP = 2'b01; end
      S_ERR2:  HRESP = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    state_n    = S_IDLE;
    wait_cnt_n = wait_cnt;
    case (state)
      S_WAIT: begin
        wait_cnt_n = wait_cnt - 4'd1;
        state_n    = (wait_cnt == 4'd1) ? S_DATA : S_WAIT;
      end
      S_ERR1:  state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
    if (slot_open && accept) begin
      if (req_err) begin
        state_n = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_n    = S_WAIT;
        wait_cnt_n = 4'(WAIT_STATES);
      end else begin
        state_n = S_DATA;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      lanes_q  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (slot_open && accept) begin
        idx_q   <= HADDR[AW+1:2];
        write_q <= HWRITE;
        lanes_q <= lanes_a;
      end
    end
  end

  // Write commits at the closing edge of the data phase; a reset on that edge suppresses it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && write_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lanes_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == S_DATA && !write_q) ? mem[idx_q] : '0;

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite responder (slave) block with word-organised internal memory. It answers transfers issued by the bus master.
- Supports byte, halfword and word accesses, a configurable number of wait states, and the two-cycle ERROR response.
- Sits behind the address decoder. It is the target end of the master's HTRANS/HADDR/HWRITE/HWDATA interface.

Parameters:
- MEM_DEPTH, 256, number of 32-bit words in memory; valid word index is HADDR[31:2] < MEM_DEPTH.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).

Ports:
- HCLK  input  1  bus clock.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from the decoder.
- HADDR  input  32  transfer address.
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  000 = byte, 001 = half, 010 = word; others unsupported.
- HBURST  input  3  ignored (each beat is handled independently).
- HPROT  input  4  ignored.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWDATA  input  32  write data, valid in the data phase.
- HREADY  input  1  global bus ready (also serves as the address-phase qualifier).
- HREADYOUT  output  1  slave ready.
- HRESP  output  2  00 OKAY, 01 ERROR.
- HRDATA  output  32  read data.

Interface decision: one clock, HCLK. Reset HRESET is synchronous and active-high.

Behaviour:
- Reset: while HRESET=1 at a rising HCLK edge, the block sets HREADYOUT=1, HRESP=00, HRDATA=0, state=S_IDLE, wait counter=0, pending flags cleared. Memory contents are not reset. A reset during S_WAIT or S_ERR1 aborts the transfer; the pending write is never committed.
- Address-phase sample: a transfer is accepted when HSEL & HREADY & HTRANS[1] at a rising edge. On acceptance the block latches address, HWRITE and HSIZE.
- IDLE/BUSY, or HSEL=0: no access, and the next data phase is zero-wait OKAY.
- Error check at accept: an accepted transfer is an ERROR if any of the following holds:
  - HADDR[31:2] >= MEM_DEPTH;
  - HSIZE > 010;
  - HSIZE=001 with HADDR[0]=1;
  - HSIZE=010 with HADDR[1:0] != 00.
- State machine:
  - S_IDLE: HREADYOUT=1, HRESP=00.
    - Accept error -> S_ERR1.
    - Accept OK with WAIT_STATES>0 -> S_WAIT, counter loaded with WAIT_STATES.
    - Accept OK with WAIT_STATES=0 -> S_DATA.
  - S_WAIT: HREADYOUT=0, HRESP=00, counter decrements each cycle. Counter reaching 1 -> S_DATA.
  - S_DATA: HREADYOUT=1, HRESP=00, final data-phase cycle.
    - Write: at the closing edge, merge HWDATA byte lanes into the word.
    - Simultaneous new accept -> follow the S_IDLE accept rules. Otherwise -> S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=01 -> S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=01, no memory write. Simultaneous new accept is legal and follows the accept rules.
- Byte lanes (little-endian):
  - Byte: lane = addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Unselected bytes are preserved.
- Read data: HRDATA = full word mem[latched index], combinational from memory, driven while in S_DATA for a read; otherwise HRDATA=0.
  - Because writes commit at the end of the data phase, a back-to-back write followed by a read of the same word returns the new data.
- Pipelining: the next address phase overlaps the current data phase. No address is sampled while HREADYOUT=0, because HREADY is low.
- Throughput: with WAIT_STATES=0, back-to-back accesses sustain one transfer per cycle.

Test Plan:
- Reset: hold HRESET=1 for 2 cycles -> HREADYOUT=1, HRESP=00, HRDATA=0.
- Word write then read: write 0xDEADBEEF to 0x10 (NONSEQ, word), then read 0x10 in the following cycle -> HRDATA=0xDEADBEEF in the read data phase, HRESP=00, zero wait states.
- Byte and half writes: after a word write of 0x00000000 to 0x20, byte write 0xAA at 0x22 and half write 0x1234 at 0x20 -> read 0x20 returns 0x00AA1234.
- Wait states: WAIT_STATES=2, read 0x10 -> HREADYOUT low for exactly 2 cycles, then high with data; HTRANS changes during the wait are not sampled.
- Errors:
  - Word read at 0x402 (misaligned) -> HREADYOUT 0 then 1, HRESP=01 for both cycles.
  - Write to 0x400 with MEM_DEPTH=256 (out of range) -> same ERROR response, memory unchanged.
  - HSIZE=011 -> same ERROR response.
- Reset mid-wait: WAIT_STATES=3, write 0x55 to 0x30, assert HRESET in the 2nd wait cycle -> block returns to S_IDLE and mem[0x30>>2] keeps its old value. BUSY/IDLE HTRANS with HSEL=1 -> OKAY, no access.
